// File: rtl/cl_stat_multi_slave_if.sv
// Stat-bus bundle for cl_stat_multi_slave: one address/strobe/data lane per channel.
// The shell side drives requests (master); the custom-logic responder acks them (slave).
interface cl_stat_multi_slave_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 8
);
  logic [NUM_CH*ADDR_W-1:0] stat_addr;
  logic [NUM_CH-1:0]        stat_wr;
  logic [NUM_CH-1:0]        stat_rd;
  logic [NUM_CH*32-1:0]     stat_wdata;
  logic [NUM_CH-1:0]        stat_ack;
  logic [NUM_CH*32-1:0]     stat_rdata;

  modport master (
    output stat_addr, stat_wr, stat_rd, stat_wdata,
    input  stat_ack, stat_rdata
  );

  modport slave (
    input  stat_addr, stat_wr, stat_rd, stat_wdata,
    output stat_ack, stat_rdata
  );
endinterface

// File: rtl/cl_stat_multi_slave.sv
// Multi-channel stat-bus responder: per-channel register bank (version, ID, W1C interrupts,
// drop counter, scratch) behind a fixed-latency ack FSM, plus the design's reset synchroniser.
module cl_stat_multi_slave #(
  parameter int          NUM_CH          = 3,
  parameter int          ADDR_W          = 8,
  parameter int          NUM_SCRATCH     = 4,
  parameter int          ACK_LAT         = 2,
  parameter logic [31:0] VERSION         = 32'hEEEE_EE00,
  parameter int          RST_SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     sync_rst_n,
  cl_stat_multi_slave_if.slave     stat,
  input  logic [NUM_CH*8-1:0]      evt_in,
  output logic [NUM_CH*8-1:0]      stat_int
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam int         WW       = ADDR_W - 2;
  localparam logic [3:0] CNT_LOAD = 4'(ACK_LAT - 1);

  logic [RST_SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[RST_SYNC_STAGES-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign sync_rst_n = sync_q[RST_SYNC_STAGES-1];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WW-1:0]  in_word;
    logic           in_wr;
    logic           in_rd;
    logic [31:0]    in_wdata;
    logic [7:0]     in_evt;
    logic           req;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [WW-1:0]  word_q, word_d;
    logic           is_wr_q, is_wr_d;
    logic [7:0]     status_q, status_d;
    logic [7:0]     mask_q, mask_d;
    logic [7:0]     int_q, int_d;
    logic [15:0]    drop_q, drop_d;
    logic [31:0]    scratch_q [NUM_SCRATCH];
    logic [31:0]    scratch_d [NUM_SCRATCH];
    logic [7:0]     w1c;
    logic [31:0]    rd_val;
    logic           ack;

    // Byte address bits [1:0] are dropped here so decode works on word offsets.
    assign in_word  = stat.stat_addr[c*ADDR_W+2 +: WW];
    assign in_wr    = stat.stat_wr[c];
    assign in_rd    = stat.stat_rd[c];
    assign in_wdata = stat.stat_wdata[c*32 +: 32];
    assign in_evt   = evt_in[c*8 +: 8];
    assign req      = (in_wr | in_rd) & sync_rst_n;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      is_wr_d   = is_wr_q;
      mask_d    = mask_q;
      drop_d    = drop_q;
      scratch_d = scratch_q;
      w1c       = '0;
      int_d     = status_q & mask_q;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
            word_d  = in_word;
            is_wr_d = in_wr;
            if (in_wr) begin
              if (in_word == WW'(2)) w1c    = in_wdata[7:0];
              if (in_word == WW'(3)) mask_d = in_wdata[7:0];
              if (in_word == WW'(4)) drop_d = '0;
              for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (in_word == WW'(8 + i)) scratch_d[i] = in_wdata;
              end
            end
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) state_d = ST_IDLE;
          else               cnt_d   = cnt_q - 4'd1;
          // Requests landing while busy are never acked, only counted.
          if (req && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        end
        default: state_d = ST_IDLE;
      endcase
      status_d = (status_q & ~w1c) | in_evt;
    end

    always_comb begin
      rd_val = 32'hDEAD_BEEF;
      if      (word_q == WW'(0)) rd_val = VERSION;
      else if (word_q == WW'(1)) rd_val = 32'(c);
      else if (word_q == WW'(2)) rd_val = {24'h0, status_q};
      else if (word_q == WW'(3)) rd_val = {24'h0, mask_q};
      else if (word_q == WW'(4)) rd_val = {16'h0, drop_q};
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (word_q == WW'(8 + i)) rd_val = scratch_q[i];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        word_q   <= '0;
        is_wr_q  <= 1'b0;
        status_q <= '0;
        mask_q   <= '0;
        int_q    <= '0;
        drop_q   <= '0;
        for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        word_q    <= word_d;
        is_wr_q   <= is_wr_d;
        status_q  <= status_d;
        mask_q    <= mask_d;
        int_q     <= int_d;
        drop_q    <= drop_d;
        scratch_q <= scratch_d;
      end
    end

    assign ack                      = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    assign stat.stat_ack[c]         = ack;
    assign stat.stat_rdata[c*32 +: 32] = (ack && !is_wr_q) ? rd_val : 32'h0;
    assign stat_int[c*8 +: 8]       = int_q;
  end

endmodule

// File: doc/cl_stat_multi_slave.md
# cl_stat_multi_slave

Parametrised stat-bus responder for custom logic. It terminates NUM_CH shell stat channels (DDR, HMC, Aurora and similar) and replaces per-channel constant tie-offs with a live register bank per channel. Each channel has a version/ID, an interrupt status/mask pair driven by local event pulses, a drop counter and scratch registers, with a configurable ack latency. It also generates the design's synchronised reset with a configurable stage count.

## Interface
- NUM_CH, 3, number of independent stat channels (1..8)
- ADDR_W, 8, stat address width; byte address, bits [1:0] ignored
- NUM_SCRATCH, 4, scratch registers per channel (1..8)
- ACK_LAT, 2, request-to-ack latency in cycles (1..8)
- VERSION, 32'hEEEE_EE00, value returned at offset 0x00
- RST_SYNC_STAGES, 2, reset synchroniser depth (2..4)

Ports (clock and reset first):
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- sync_rst_n  out  1  synchronised reset; async assert, deasserts RST_SYNC_STAGES rising edges after rst_n rises
- stat_addr  in  NUM_CH*ADDR_W  per-channel address, channel c at [c*ADDR_W +: ADDR_W]
- stat_wr  in  NUM_CH  per-channel single-cycle write strobe
- stat_rd  in  NUM_CH  per-channel single-cycle read strobe
- stat_wdata  in  NUM_CH*32  per-channel write data
- stat_ack  out  NUM_CH  one-cycle ack per completed request
- stat_rdata  out  NUM_CH*32  read data; valid only with ack
- stat_int  out  NUM_CH*8  per-channel interrupt lines, registered
- evt_in  in  NUM_CH*8  per-channel event pulses; each bit sets the matching INT_STATUS bit

## Operation
- Channels are fully independent. The logic below is replicated per channel.
- Register map (offset):
  - 0x00 VERSION, RO.
  - 0x04 ID = {24'h0, channel index}, RO.
  - 0x08 INT_STATUS[7:0], W1C.
  - 0x0C INT_MASK[7:0], RW, 1 = enabled.
  - 0x10 DROP_CNT[15:0], RO; any write clears it.
  - 0x20+4*i SCRATCH[i], RW, for i < NUM_SCRATCH.
  - All other offsets read 32'hDEAD_BEEF; writes to them are ignored but still acked.
- Per-channel FSM:
  - IDLE → BUSY on wr|rd. Capture addr, wdata and type; load the countdown with ACK_LAT-1.
  - BUSY: decrement each cycle. At 0, pulse ack and return to IDLE.
  - With ACK_LAT=1, the FSM acks in the first BUSY cycle.
- wr and rd asserted together: treated as a write; ack once, rdata = 0.
- A request arriving in BUSY is dropped (no ack). DROP_CNT increments and saturates at 16'hFFFF.
- Requests are ignored while sync_rst_n = 0.
- INT_STATUS update priority per bit: evt_in set > W1C clear > hold.
- stat_int = registered (INT_STATUS & INT_MASK).
- Unused read bits return 0.

## Timing
- Request sampled at edge T.
- Write side effects are visible from T+1. A read captures register contents at T+ACK_LAT-1 (the ack edge's input).
- ack is high exactly during cycle T+ACK_LAT. rdata equals the read value in that cycle and is 0 in all other cycles.
- BUSY spans cycles T+1..T+ACK_LAT. The earliest accepted next request is at T+ACK_LAT+1, giving 1 request per ACK_LAT+1 cycles.
- An evt_in bit at edge E sets INT_STATUS at E+1; stat_int reflects it at E+2.
- Reset values:
  - stat_ack = 0, stat_rdata = 0, stat_int = 0, sync_rst_n = 0.
  - INT_STATUS = 0, INT_MASK = 0, DROP_CNT = 0, SCRATCH = 0, FSM = IDLE.
- Reset mid-operation: a pending ack is cancelled and never issued after reset; all outputs go to 0 asynchronously.

## Test plan
- Reset release: rst_n rises → sync_rst_n = 1 after exactly RST_SYNC_STAGES edges. A rd on 0x00 before that → no ack. After it, rd 0x00 → ack at T+2 with 0xEEEE_EE00.
- Scratch and ID: ch1 wr 0x24 = 0x1234_5678, then rd 0x24 → 0x1234_5678. rd 0x04 on ch2 → 0x0000_0002. rd 0x7C → 0xDEAD_BEEF.
- Interrupts: mask = 0x05, evt_in ch0 = 0x07 → status 0x07, stat_int 0x05 two cycles later. W1C 0x01 in the same cycle as evt bit0 → status stays 0x07. A later W1C 0x07 → status 0, stat_int 0.
- Busy drop: rd at T and a second rd at T+1 (ACK_LAT=2) → single ack at T+2 and DROP_CNT = 1. A rd at T+3 is accepted.
- Simultaneous channels and wr+rd: wr+rd on ch0 to 0x20 = 0xA5 while ch2 reads 0x00 in the same cycle → both ack at T+2; ch0 rdata = 0, scratch0 = 0xA5.
- Mid-op reset: rd accepted, rst_n low at T+1 → no ack ever. After release, all registers read back 0.
